// File: rtl/frame_proc_fsm_param.sv
// frame_proc_fsm_param: frame sequencer (preamble, SOF, data, CRC, EOP, gap) driving a CRC generator and framing-word ROM.
// Define FRAME_PROC_TMR_EN to triplicate all registers with majority voting.
module frame_proc_fsm_param #(
    parameter int N_PRE   = 3,
    parameter int N_EOP   = 3,
    parameter int AW      = 3,
    parameter int MAX_LEN = 1024,
    parameter int IFG     = 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           VALID,
    output logic                           CLR_CRC,
    output logic                           CRC_DV,
    output logic [AW-1:0]                  ROM_ADDR,
    output logic                           TX_ACK,
    output logic                           FRM_ERR,
    output logic [$clog2(MAX_LEN+1)-1:0]   FRM_LEN,
    output logic [3:0]                     FRM_STATE
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = (AW > 4) ? AW : 4;
`ifdef FRAME_PROC_TMR_EN
    localparam int NC = 3;
`else
    localparam int NC = 1;
`endif

    typedef enum logic [3:0] {IDLE, SOP, PRE, SOF, STRT, DATA, CRC, EOP, GAP} state_e;

    typedef struct packed {
        state_e          st;
        logic [SW-1:0]   sub;
        logic [LW-1:0]   cnt;
        logic            drain;
        logic [LW-1:0]   len;
        logic            clr;
        logic            dv;
        logic [AW-1:0]   addr;
        logic            ack;
        logic            err;
    } regs_t;

    regs_t         r_q [NC];
    regs_t         r_d;
    regs_t         v;
    state_e        nxt;
    logic [LW-1:0] inc;
    logic          trunc;

`ifdef FRAME_PROC_TMR_EN
    assign v = (r_q[0] & r_q[1]) | (r_q[0] & r_q[2]) | (r_q[1] & r_q[2]);
`else
    assign v = r_q[0];
`endif

    always_comb begin
        inc   = (v.cnt == LW'(MAX_LEN)) ? v.cnt : v.cnt + 1'b1;
        trunc = (v.st == DATA) && VALID && (inc == LW'(MAX_LEN));
        nxt   = IDLE;
        case (v.st)
            IDLE:    nxt = (VALID && !v.drain) ? SOP : IDLE;
            SOP:     nxt = PRE;
            PRE:     nxt = (v.sub == SW'(N_PRE - 1)) ? SOF : PRE;
            SOF:     nxt = STRT;
            STRT:    nxt = DATA;
            DATA:    nxt = (!VALID || inc == LW'(MAX_LEN)) ? CRC : DATA;
            CRC:     nxt = EOP;
            EOP:     nxt = (v.sub == SW'(N_EOP - 1)) ? ((IFG == 0) ? IDLE : GAP) : EOP;
            GAP:     nxt = (v.sub == SW'(IFG - 1)) ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
        r_d       = v;
        r_d.st    = nxt;
        r_d.sub   = (nxt == v.st) ? v.sub + 1'b1 : '0;
        r_d.cnt   = (nxt == SOP) ? '0 : (v.st == STRT || v.st == DATA) ? inc : v.cnt;
        r_d.len   = (nxt == CRC) ? inc : v.len;
        r_d.err   = trunc;
        r_d.drain = !VALID ? 1'b0 : (trunc | v.drain);
        r_d.clr   = nxt inside {SOP, PRE, SOF};
        r_d.dv    = nxt inside {STRT, DATA};
        r_d.ack   = (nxt == SOF);
        // EOP words are addressed from 4 upward, one per EOP cycle
        r_d.addr  = (nxt == PRE) ? AW'(1) :
                    (nxt == SOF) ? AW'(2) :
                    (nxt inside {STRT, DATA, CRC}) ? AW'(3) :
                    (nxt == EOP) ? AW'(4) + r_d.sub[AW-1:0] : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) for (int i = 0; i < NC; i++) r_q[i] <= '0;
        else        for (int i = 0; i < NC; i++) r_q[i] <= r_d;
    end

    assign FRM_STATE = v.st;
    assign CLR_CRC   = v.clr;
    assign CRC_DV    = v.dv;
    assign ROM_ADDR  = v.addr;
    assign TX_ACK    = v.ack;
    assign FRM_ERR   = v.err;
    assign FRM_LEN   = v.len;
endmodule

// File: tb/tb_frame_proc_fsm_param.sv
// tb_frame_proc_fsm_param: directed checks of frame sequencing, truncation, back-to-back, reset and short-parameter build.
module tb_frame_proc_fsm_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic       v2 = 1'b0;
    logic       clr, dv, ack, err, clr2, dv2, ack2, err2;
    logic [2:0] addr, addr2;
    logic [3:0] len, len2;
    logic [3:0] st, st2;
    int         checks = 0;
    int         errors = 0;

    frame_proc_fsm_param #(.MAX_LEN(8)) dut (
        .CLK(clk), .RST_N(rst_n), .VALID(valid), .CLR_CRC(clr), .CRC_DV(dv),
        .ROM_ADDR(addr), .TX_ACK(ack), .FRM_ERR(err), .FRM_LEN(len), .FRM_STATE(st)
    );

    frame_proc_fsm_param #(.N_PRE(1), .N_EOP(1), .IFG(0), .MAX_LEN(8)) dut2 (
        .CLK(clk), .RST_N(rst_n), .VALID(v2), .CLR_CRC(clr2), .CRC_DV(dv2),
        .ROM_ADDR(addr2), .TX_ACK(ack2), .FRM_ERR(err2), .FRM_LEN(len2), .FRM_STATE(st2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int s, input int lim);
        int n = 0;
        while (int'(st) != s && n < lim) begin
            step();
            n++;
        end
        check("wait_state", int'(st), s);
    endtask

    int nom_st   [16] = '{1, 2, 2, 2, 3, 4, 5, 5, 5, 6, 7, 7, 7, 8, 8, 0};
    int nom_addr [16] = '{0, 1, 1, 1, 2, 3, 3, 3, 3, 3, 4, 5, 6, 0, 0, 0};
    int nom_flg  [16] = '{4, 4, 4, 4, 5, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0};
    int sh_st    [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
    int sh_addr  [8]  = '{0, 1, 2, 3, 3, 3, 4, 0};

    initial begin
        int dvn, n, sops;
        #2 rst_n = 1'b0;
        repeat (2) step();
        check("rst_state", st, 0);
        check("rst_flags", {clr, dv, ack, err}, 0);
        check("rst_addr", addr, 0);
        check("rst_len", len, 0);
        check("rst_state2", st2, 0);
        rst_n = 1'b1;
        step();
        valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("nom_state_%0d", k + 1), st, nom_st[k]);
            check($sformatf("nom_addr_%0d", k + 1), addr, nom_addr[k]);
            check($sformatf("nom_flags_%0d", k + 1), {clr, dv, ack}, nom_flg[k]);
            check($sformatf("nom_err_%0d", k + 1), err, 0);
            if (k == 8) valid = 1'b0;
        end
        check("nom_len", len, 4);

        valid = 1'b1;
        dvn = 0;
        n = 0;
        while (st != 4'd6 && n < 40) begin
            step();
            if (dv) dvn++;
            n++;
        end
        check("trunc_crc", st, 6);
        check("trunc_dv_cycles", dvn, 8);
        check("trunc_err", err, 1);
        check("trunc_len", len, 8);
        step();
        check("trunc_err_once", err, 0);
        sops = 0;
        repeat (12) begin
            step();
            if (st == 4'd1) sops++;
        end
        check("drain_no_sop", sops, 0);
        check("drain_idle", st, 0);
        valid = 1'b0;
        step();
        valid = 1'b1;
        step();
        check("drain_release_sop", st, 1);

        wait_st(5, 10);
        valid = 1'b0;
        step();
        check("short_crc", st, 6);
        check("short_len", len, 2);
        valid = 1'b1;
        wait_st(8, 10);
        step();
        check("b2b_gap2", st, 8);
        step();
        check("b2b_idle", st, 0);
        step();
        check("b2b_sop", st, 1);

        wait_st(5, 10);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", st, 0);
        check("arst_flags", {clr, dv, ack, err}, 0);
        check("arst_addr", addr, 0);
        check("arst_len", len, 0);
        valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_idle", st, 0);

        v2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("p1_state_%0d", k + 1), st2, sh_st[k]);
            check($sformatf("p1_addr_%0d", k + 1), addr2, sh_addr[k]);
            if (k == 4) v2 = 1'b0;
        end
        check("p1_len", len2, 2);

`ifdef FRAME_PROC_TMR_EN
        valid = 1'b1;
        wait_st(5, 12);
        force dut.r_q[1] = '1;
        #1;
        check("tmr_state", st, 5);
        check("tmr_flags", {clr, dv, ack}, 2);
        release dut.r_q[1];
        step();
        check("tmr_resync", int'(dut.r_q[1].st), 5);
        valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
